truth_table_checker: RTL and testbench
======================================

// Module: truth_table_checker
// PURPOSE
//   Exhaustive on-chip stimulus/response engine for small combinational gates (and4, or4, ...).
//   Steps x through all 2**N_IN input patterns and holds each for DWELL clocks.
//   Compares the DUT output z against the EXPECTED truth table and reports pass/fail,
//   mismatch count and first failing pattern. Sits between board-level control (button/LEDs)
//   and the gate under test; hardware counterpart of the gate testbenches.
// PARAMETERS
//   N_IN      4        number of DUT inputs; patterns 0 .. 2**N_IN-1 (range 1..6)
//   DWELL     4        clocks each pattern is held; z sampled on last one (>= 2)
//   EXPECTED  16'h8000 golden truth table, bit p = required z for pattern p (default = AND4)
// PORTS
//   clk         in   1       system clock (12 MHz on board)
//   rst         in   1       asynchronous, active-high reset
//   start       in   1       run request, sampled on rising clk; level or pulse
//   z           in   1       DUT output; DUT combinational from x
//   x           out  N_IN    applied pattern; x[i] = bit i of pattern index (x[N_IN-1] = MSB)
//   busy        out  1       high while sweeping
//   done        out  1       high from end of sweep until next run starts
//   pass        out  1       valid with done: 1 iff err_count == 0
//   err_count   out  N_IN+1  number of mismatching patterns (0 .. 2**N_IN, no wrap)
//   first_fail  out  N_IN    lowest failing pattern index, valid when fail_valid
//   fail_valid  out  1       at least one mismatch seen this run
// BEHAVIOUR
//   Reset (async assert, any state): FSM=IDLE, all outputs 0, idx=0, dwell_cnt=0.
//   Reset mid-sweep discards partial results; no output glitch other than the clear.
//   FSM states: IDLE, RUN, DONE; all outputs registered.
//   IDLE: x=0, busy=0. start=1 at edge -> RUN; same edge: idx=0, dwell_cnt=0,
//     err_count=0, fail_valid=0, first_fail=0, done=0, pass=0, busy=1.
//   RUN: x=idx. dwell_cnt counts 0..DWELL-1.
//     On edge with dwell_cnt==DWELL-1: compare z with EXPECTED[idx].
//     Mismatch -> err_count+1. If fail_valid==0, first_fail=idx and fail_valid=1.
//     Same edge: idx==2**N_IN-1 -> DONE, else idx+1 and dwell_cnt=0.
//     start ignored in RUN.
//   DONE: busy=0, done=1, pass=(final err_count==0); x holds last pattern.
//     Results hold indefinitely. start=1 -> restart exactly as from IDLE (clears results).
//   Latency: start sampled at edge k -> done/pass valid after edge k + DWELL*2**N_IN
//     (64 clocks at defaults). Each pattern is visible on x for exactly DWELL clocks.
//   Settling: z is sampled DWELL-1 clocks after x changes; DWELL>=2 guarantees >= 1 full
//     clock of settle. z is sampled combinationally, with no synchronizer.
//   Mismatch on the last pattern updates err_count/pass in the same edge that enters DONE.
//   EXPECTED bits above 2**N_IN-1 are ignored.
// TESTING
//   1 and4 model, defaults, start pulse -> x steps 0..15, 4 clocks each;
//     done at +64 clocks; pass=1; err_count=0; fail_valid=0.
//   2 z stuck-at-0 -> err_count=1, first_fail=15, fail_valid=1, pass=0.
//   3 z stuck-at-1 -> err_count=15, first_fail=0, pass=0.
//   4 or4 model against EXPECTED=16'h8000 -> err_count=14, first_fail=1, pass=0.
//   5 rst pulsed while idx=7 -> all outputs 0 and FSM=IDLE immediately;
//     new start gives a clean full run with results identical to scenario 1.
//   6 start held high through RUN -> no restart. Pulse start in DONE after
//     stuck-at-0 run with and4 model -> done/fail flags cleared at that edge; rerun passes.

Source files
------------

// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if
//   Groups the run-control, gate-under-test and result signals of the
//   truth-table checker into one bundle.
//   master : the checker itself (drives x and all results, reads start and z)
//   slave  : the environment (board control plus gate under test)
//   Signals:
//     start       run request (level or pulse)
//     z           output of the gate under test
//     x           pattern applied to the gate, x[i] = bit i of the pattern index
//     busy        high while sweeping
//     done        high from end of sweep until the next run starts
//     pass        valid with done, 1 iff err_count == 0
//     err_count   number of mismatching patterns, 0 .. 2**N_IN
//     first_fail  lowest failing pattern index, valid when fail_valid
//     fail_valid  at least one mismatch seen this run
interface truth_table_checker_if #(
    parameter int N_IN = 4
);
    logic            start;
    logic            z;
    logic [N_IN-1:0] x;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;
    logic            fail_valid;

    modport master (
        input  start, z,
        output x, busy, done, pass, err_count, first_fail, fail_valid
    );

    modport slave (
        output start, z,
        input  x, busy, done, pass, err_count, first_fail, fail_valid
    );
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker
//   Exhaustive stimulus/response engine for a small combinational gate.
//   On start it sweeps x through all 2**N_IN patterns, holding each for DWELL
//   clocks, samples z on the last clock of each pattern and compares it with
//   bit p of EXPECTED. Reports pass/fail, mismatch count and the lowest
//   failing pattern. All outputs come straight from registers.
//   Ports:
//     clk    system clock
//     rst    asynchronous, active-high reset
//     tt_if  master side of truth_table_checker_if (start/z in, x and results out)
module truth_table_checker #(
    parameter int          N_IN     = 4,
    parameter int          DWELL    = 4,
    parameter logic [63:0] EXPECTED = 64'h8000
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_checker_if.master tt_if
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            fv_q, fv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic [5:0]      exp_idx;
    logic            mismatch;

    // Patterns beyond 2**N_IN never occur, so the upper EXPECTED bits are unused.
    assign exp_idx  = 6'(idx_q);
    assign mismatch = (tt_if.z != EXPECTED[exp_idx]);

    // State register: every piece of state lives here.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values they held before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic.
    // NOTE: every _d gets a hold default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fv_d    = fv_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        unique case (state_q)
            IDLE, DONE: begin
                // A restart from DONE behaves exactly like a start from IDLE.
                if (tt_if.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    dwell_d = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end

            RUN: begin
                // start is deliberately ignored while sweeping.
                if (dwell_q == DW_W'(DWELL - 1)) begin
                    err_d = err_q + (N_IN + 1)'(mismatch);
                    if (mismatch && !fv_q) begin
                        ff_d = idx_q;
                        fv_d = 1'b1;
                    end
                    if (idx_q == {N_IN{1'b1}}) begin
                        // Last pattern: its result is folded into pass on the same edge.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d   = idx_q + N_IN'(1);
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: pure wiring from registers, so no output can glitch.
    // x is the pattern index itself; it is 0 in IDLE and holds the last
    // pattern in DONE.
    always_comb begin
        tt_if.x          = idx_q;
        tt_if.busy       = busy_q;
        tt_if.done       = done_q;
        tt_if.pass       = pass_q;
        tt_if.err_count  = err_q;
        tt_if.first_fail = ff_q;
        tt_if.fail_valid = fv_q;
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker
//   Drives truth_table_checker (defaults: N_IN=4, DWELL=4, EXPECTED=AND4) with
//   a behavioural gate model on z and checks every completed sweep against a
//   reference computed directly from the truth-table rules.
module tb_truth_table_checker;

    localparam int          N_IN  = 4;
    localparam int          DWELL = 4;
    localparam int          NP    = 1 << N_IN;
    localparam logic [63:0] EXP   = 64'h8000;
    localparam int          RUN_CYCLES = DWELL * NP;

    typedef enum int {M_AND, M_OR, M_S0, M_S1, M_TT} mode_e;

    typedef struct {
        int     err;
        int     ff;
        bit     fv;
        bit     pass;
        longint cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    mode_e       mode;
    logic [15:0] tt_v;
    longint      cyc;
    int          checks;
    int          failures;
    exp_t        sb[$];
    exp_t        cur_exp;
    int          hist[NP];
    logic        done_prev;

    truth_table_checker_if #(.N_IN(N_IN)) tt_if ();

    truth_table_checker #(
        .N_IN    (N_IN),
        .DWELL   (DWELL),
        .EXPECTED(EXP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .tt_if(tt_if.master)
    );

    // Gate under test: a behavioural model selected by mode.
    function automatic bit gate(mode_e m, int p, logic [15:0] tt);
        case (m)
            M_AND:   return (p == NP - 1);
            M_OR:    return (p != 0);
            M_S0:    return 1'b0;
            M_S1:    return 1'b1;
            default: return tt[p];
        endcase
    endfunction

    assign tt_if.z = gate(mode, int'(tt_if.x), tt_v);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: walk the truth table once and count disagreements.
    function automatic exp_t model(mode_e m, logic [15:0] tt, longint done_cyc);
        exp_t e;
        e.err  = 0;
        e.ff   = 0;
        e.fv   = 1'b0;
        e.cyc  = done_cyc;
        for (int p = 0; p < NP; p++) begin
            if (gate(m, p, tt) != EXP[p]) begin
                if (!e.fv) e.ff = p;
                e.fv = 1'b1;
                e.err++;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    // Issue a start at this negedge; the DUT samples it on the next posedge.
    task automatic issue_start(input mode_e m, input logic [15:0] tt);
        mode  = m;
        tt_v  = tt;
        tt_if.start = 1'b1;
        for (int p = 0; p < NP; p++) hist[p] = 0;
        cur_exp = model(m, tt, cyc + 1 + RUN_CYCLES);
        sb.push_back(cur_exp);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!tt_if.done && n < RUN_CYCLES + 20) begin
            @(negedge clk);
            n++;
        end
        if (!tt_if.done) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout: done not seen after %0d cycles", name, n);
            sb.delete();
        end
    endtask

    task automatic run_pulse(input string name, input mode_e m, input logic [15:0] tt);
        @(negedge clk);
        issue_start(m, tt);
        @(negedge clk);
        tt_if.start = 1'b0;
        wait_done(name);
    endtask

    // Monitor: on each rising done, pop the expected result and compare.
    initial done_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && tt_if.busy) begin
            hist[int'(tt_if.x)]++;
        end
        if (tt_if.done && !done_prev) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done rose with no run pending");
            end else begin
                exp_t e;
                int   bad;
                e = sb.pop_front();
                check("err_count",  tt_if.err_count,  e.err);
                check("first_fail", tt_if.first_fail, e.ff);
                check("fail_valid", tt_if.fail_valid, e.fv);
                check("pass",       tt_if.pass,       e.pass);
                check("busy_off",   tt_if.busy,       0);
                check("latency",    cyc,              e.cyc);
                check("x_last",     tt_if.x,          NP - 1);
                bad = 0;
                for (int p = 0; p < NP; p++) if (hist[p] != DWELL) bad++;
                check("dwell_patterns_wrong", bad, 0);
            end
        end
        done_prev = tt_if.done;
    end

    task automatic check_all_zero(input string name);
        check({name, "_x"},    tt_if.x,          0);
        check({name, "_busy"}, tt_if.busy,       0);
        check({name, "_done"}, tt_if.done,       0);
        check({name, "_pass"}, tt_if.pass,       0);
        check({name, "_err"},  tt_if.err_count,  0);
        check({name, "_ff"},   tt_if.first_fail, 0);
        check({name, "_fv"},   tt_if.fail_valid, 0);
    endtask

    initial begin
        int n;
        checks      = 0;
        failures    = 0;
        mode        = M_AND;
        tt_v        = '0;
        rst         = 1'b1;
        tt_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        // Known gates against the AND4 table.
        run_pulse("and4", M_AND, '0);
        // Results must hold while nothing happens.
        repeat (10) @(negedge clk);
        check("hold_done", tt_if.done,      1);
        check("hold_err",  tt_if.err_count, cur_exp.err);
        run_pulse("stuck0", M_S0, '0);
        run_pulse("stuck1", M_S1, '0);
        run_pulse("or4",    M_OR, '0);

        // Reset mid-sweep at pattern 7.
        @(negedge clk);
        issue_start(M_AND, '0);
        @(negedge clk);
        tt_if.start = 1'b0;
        n = 0;
        while (tt_if.x != 7 && n < RUN_CYCLES) begin
            @(negedge clk);
            n++;
        end
        check("reached_idx7", tt_if.x, 7);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_rst");
        run_pulse("after_rst", M_AND, '0);

        // start held high through most of RUN must not restart the sweep.
        @(negedge clk);
        issue_start(M_AND, '0);
        repeat (RUN_CYCLES - 20) @(negedge clk);
        check("held_busy", tt_if.busy, 1);
        tt_if.start = 1'b0;
        wait_done("held");

        // Stuck-at-0 run, then restart from DONE with a good gate.
        run_pulse("s0_again", M_S0, '0);
        repeat (3) @(negedge clk);
        issue_start(M_AND, '0);
        @(negedge clk);
        tt_if.start = 1'b0;
        check("restart_done", tt_if.done,       0);
        check("restart_fv",   tt_if.fail_valid, 0);
        check("restart_err",  tt_if.err_count,  0);
        check("restart_busy", tt_if.busy,       1);
        check("restart_pass", tt_if.pass,       0);
        wait_done("restart");

        // Randomized gates, including the occasional correct one.
        for (int r = 0; r < 8; r++) begin
            logic [15:0] t;
            t = 16'($urandom);
            if (r % 4 == 3) t = 16'h8000;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            run_pulse("random", M_TT, t);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
